// File: rtl/jls_frame_feeder.sv
// jls_frame_feeder
// Pixel-stream front end for jls_encoder. Accepts an image header plus a
// valid/ready pixel stream and produces the encoder frame protocol: an o_sof
// preamble carrying the latched size, a pixel-enable stream with optional
// fixed or pseudo-random bubbles, and an all-zero inter-frame gap.
//
// Ports:
//   clk      clock
//   rstn     synchronous active-low reset
//   i_start  frame start request (sampled only while idle)
//   i_w/i_h  image width/height minus 1
//   i_bmode  bubble mode: 0/3 none, 1 fixed i_bnum, 2 random 0..i_bnum
//   i_bnum   bubble count or bound
//   s_valid/s_ready/s_data  source pixel stream
//   o_sof/o_w/o_h/o_e/o_x   encoder-facing frame protocol (registered)
//   o_busy   frame in progress, o_done end-of-gap pulse, o_err rejected start
module jls_frame_feeder #(
  parameter int          XW          = 8,
  parameter int          WW          = 14,
  parameter int          SOF_CYCLES  = 368,
  parameter int          IDLE_CYCLES = 16,
  parameter int          BW          = 4,
  parameter int          MIN_W       = 5,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_start,
  input  logic [WW-1:0] i_w,
  input  logic [WW-1:0] i_h,
  input  logic [1:0]    i_bmode,
  input  logic [BW-1:0] i_bnum,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [XW-1:0] s_data,
  output logic          o_sof,
  output logic [WW-1:0] o_w,
  output logic [WW-1:0] o_h,
  output logic          o_e,
  output logic [XW-1:0] o_x,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  // One shared counter serves the preamble, bubble and gap phases.
  localparam int CMAX0 = (SOF_CYCLES > IDLE_CYCLES) ? SOF_CYCLES : IDLE_CYCLES;
  localparam int CMAX  = (CMAX0 > (1 << BW)) ? CMAX0 : (1 << BW);
  localparam int CW    = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_PIX  = 3'd2,
    ST_BUB  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  // Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] f_lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Bubble count after an accepted pixel; random mode scales lfsr[7:0] into 0..bnum.
  function automatic logic [BW-1:0] f_bubbles(input logic [1:0] mode, input logic [BW-1:0] bnum,
                                              input logic [7:0] rnd);
    logic [BW-1:0] n;
    case (mode)
      2'd1:    n = bnum;
      2'd2:    n = BW'((((BW+9)'(rnd)) * ((BW+9)'(bnum) + (BW+9)'(1))) >> 8);
      default: n = '0;
    endcase
    return n;
  endfunction

  state_t        r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [WW-1:0] r_col, w_col_n, r_row, w_row_n;
  logic [WW-1:0] r_lw, w_lw_n, r_lh, w_lh_n;
  logic [1:0]    r_bmode, w_bmode_n;
  logic [BW-1:0] r_bnum, w_bnum_n;
  logic [15:0]   r_lfsr, w_lfsr_n;
  logic          r_sof, w_sof_n, r_e, w_e_n, r_busy, w_busy_n;
  logic          r_done, w_done_n, r_err, w_err_n, r_ready, w_ready_n;
  logic [WW-1:0] r_ow, w_ow_n, r_oh, w_oh_n;
  logic [XW-1:0] r_x, w_x_n;
  logic          w_hs, w_last, w_too_narrow;
  logic [BW-1:0] w_nbub;

  assign w_hs         = s_valid & r_ready;
  assign w_last       = (r_row == r_lh) && (r_col == r_lw);
  assign w_too_narrow = ({1'b0, i_w} + (WW+1)'(1)) < (WW+1)'(MIN_W);
  assign w_nbub       = f_bubbles(r_bmode, r_bnum, r_lfsr[7:0]);

  // Next-state and next-output logic.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_col_n   = r_col;
    w_row_n   = r_row;
    w_lw_n    = r_lw;
    w_lh_n    = r_lh;
    w_bmode_n = r_bmode;
    w_bnum_n  = r_bnum;
    w_lfsr_n  = r_lfsr;
    w_sof_n   = 1'b0;
    w_ow_n    = '0;
    w_oh_n    = '0;
    w_e_n     = 1'b0;
    w_x_n     = '0;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    w_err_n   = 1'b0;
    w_ready_n = r_ready;

    case (r_state)
      ST_IDLE: begin
        w_busy_n  = 1'b0;
        w_ready_n = 1'b0;
        if (i_start) begin
          if (w_too_narrow) begin
            w_err_n = 1'b1;
          end else begin
            w_lw_n    = i_w;
            w_lh_n    = i_h;
            w_bmode_n = i_bmode;
            w_bnum_n  = i_bnum;
            w_col_n   = '0;
            w_row_n   = '0;
            w_cnt_n   = '0;
            w_state_n = ST_SOF;
            w_sof_n   = 1'b1;
            w_ow_n    = i_w;
            w_oh_n    = i_h;
            w_busy_n  = 1'b1;
            // With a one-cycle preamble the source is already ready in it.
            w_ready_n = (SOF_CYCLES == 1);
          end
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      ST_SOF: begin
        if (r_cnt == CW'(SOF_CYCLES - 1)) begin
          w_state_n = ST_PIX;
          w_ready_n = 1'b1;
        end else begin
          w_cnt_n   = r_cnt + CW'(1);
          w_sof_n   = 1'b1;
          w_ow_n    = r_lw;
          w_oh_n    = r_lh;
          // Raise ready in the final preamble cycle so pixels follow with no gap.
          w_ready_n = ({1'b0, r_cnt} + (CW+1)'(2)) >= (CW+1)'(SOF_CYCLES);
        end
      end
      ST_PIX: begin
        w_ready_n = 1'b1;
      end
      ST_BUB: begin
        if (r_cnt <= CW'(1)) begin
          w_state_n = ST_PIX;
          w_ready_n = 1'b1;
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end
      ST_GAP: begin
        w_ready_n = 1'b0;
        if (r_cnt == CW'(IDLE_CYCLES)) begin
          w_state_n = ST_IDLE;
          w_busy_n  = 1'b0;
        end else begin
          w_cnt_n  = r_cnt + CW'(1);
          w_done_n = (r_cnt == CW'(IDLE_CYCLES - 1));
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_busy_n  = 1'b0;
        w_ready_n = 1'b0;
      end
    endcase

    // An accepted pixel overrides the phase decision above (it can land in
    // the last preamble cycle as well as in PIX).
    if (w_hs) begin
      w_e_n    = 1'b1;
      w_x_n    = s_data;
      w_lfsr_n = f_lfsr_next(r_lfsr);
      if (w_last) begin
        w_state_n = ST_GAP;
        w_cnt_n   = '0;
        w_ready_n = 1'b0;
      end else begin
        if (r_col == r_lw) begin
          w_col_n = '0;
          w_row_n = r_row + WW'(1);
        end else begin
          w_col_n = r_col + WW'(1);
        end
        if (w_nbub != '0) begin
          w_state_n = ST_BUB;
          w_cnt_n   = CW'(w_nbub);
          w_ready_n = 1'b0;
        end else begin
          w_state_n = ST_PIX;
          w_ready_n = 1'b1;
        end
      end
    end else begin
      w_e_n = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_lw    <= '0;
      r_lh    <= '0;
      r_bmode <= 2'd0;
      r_bnum  <= '0;
      r_lfsr  <= LFSR_SEED;
      r_sof   <= 1'b0;
      r_ow    <= '0;
      r_oh    <= '0;
      r_e     <= 1'b0;
      r_x     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_col   <= w_col_n;
      r_row   <= w_row_n;
      r_lw    <= w_lw_n;
      r_lh    <= w_lh_n;
      r_bmode <= w_bmode_n;
      r_bnum  <= w_bnum_n;
      r_lfsr  <= w_lfsr_n;
      r_sof   <= w_sof_n;
      r_ow    <= w_ow_n;
      r_oh    <= w_oh_n;
      r_e     <= w_e_n;
      r_x     <= w_x_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
      r_err   <= w_err_n;
      r_ready <= w_ready_n;
    end
  end

  assign s_ready = r_ready;
  assign o_sof   = r_sof;
  assign o_w     = r_ow;
  assign o_h     = r_oh;
  assign o_e     = r_e;
  assign o_x     = r_x;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_err   = r_err;

endmodule

// File: tb/tb_jls_frame_feeder.sv
module tb_jls_frame_feeder;
  localparam int          XW        = 8;
  localparam int          WW        = 14;
  localparam int          SOF       = 368;
  localparam int          IDLE      = 16;
  localparam int          BW        = 4;
  localparam int          MIN_W     = 5;
  localparam logic [15:0] SEED      = 16'hACE1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_start;
  logic [WW-1:0] i_w, i_h;
  logic [1:0]    i_bmode;
  logic [BW-1:0] i_bnum;
  logic          s_valid;
  logic          s_ready;
  logic [XW-1:0] s_data;
  logic          o_sof, o_e, o_busy, o_done, o_err;
  logic [WW-1:0] o_w, o_h;
  logic [XW-1:0] o_x;

  int checks   = 0;
  int failures = 0;
  logic [15:0] m_lfsr = SEED;
  int obs_runs[$];
  int out_px[$];
  int sent_px[$];

  jls_frame_feeder #(.XW(XW), .WW(WW), .SOF_CYCLES(SOF), .IDLE_CYCLES(IDLE), .BW(BW),
                     .MIN_W(MIN_W), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_w(i_w), .i_h(i_h),
    .i_bmode(i_bmode), .i_bnum(i_bnum), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .o_sof(o_sof), .o_w(o_w), .o_h(o_h), .o_e(o_e), .o_x(o_x),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11.
  function automatic logic [15:0] model_shift(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int model_bubbles(input int mode, input int bnum, input logic [15:0] l);
    if (mode == 1) return bnum;
    if (mode == 2) return (int'(l[7:0]) * (bnum + 1)) / 256;
    return 0;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rstn = 1'b0; i_start = 1'b0; s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    m_lfsr = SEED;
  endtask

  // Drive one frame from a bench-held pixel list and check the protocol cycle by cycle.
  task automatic run_frame(input int w, input int h, input int mode, input int bnum,
                           input int vpat, input int base, input int abort_px, input bit mid_start);
    int n_px, idx, k_last, m_ready_at, n_hs, run_cnt, budget, nb, c;
    bit m_on, prev_hs, in_run, v, exp_sof, exp_busy, exp_done, exp_ready, fin;
    logic [XW-1:0] prev_x, exp_x;
    logic [WW-1:0] exp_w, exp_h;
    n_px = (w + 1) * (h + 1);
    sent_px.delete(); out_px.delete(); obs_runs.delete();
    for (int p = 0; p < n_px; p++)
      sent_px.push_back(base >= 0 ? (base + p) % 256 : int'($urandom_range(0, 255)));
    idx = 0; k_last = -1; m_on = 1'b1; m_ready_at = SOF; n_hs = 0; run_cnt = 0;
    prev_hs = 1'b0; prev_x = '0; in_run = 1'b0; fin = 1'b0; nb = 0;
    budget = SOF + IDLE + 100 + n_px * (bnum + 4) * 4;
    @(negedge clk);
    i_start = 1'b1; i_w = WW'(w); i_h = WW'(h); i_bmode = 2'(mode); i_bnum = BW'(bnum);
    s_valid = 1'b0; s_data = '0;
    for (c = 1; c <= budget && !fin; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (c == 1) begin
        i_w = WW'($urandom); i_h = WW'($urandom); i_bmode = 2'($urandom); i_bnum = BW'($urandom);
      end
      if (mid_start && c == SOF + 3) begin
        i_start = 1'b1; i_w = WW'(3);
      end
      exp_sof = (c <= SOF);
      exp_w = exp_sof ? WW'(w) : '0;
      exp_h = exp_sof ? WW'(h) : '0;
      checks++;
      if (o_sof !== exp_sof || o_w !== exp_w || o_h !== exp_h) begin
        failures++;
        $display("FAIL sof_hdr c=%0d: got sof=%0b w=%0d h=%0d expected sof=%0b w=%0d h=%0d",
                 c, o_sof, o_w, o_h, exp_sof, exp_w, exp_h);
      end
      exp_x = prev_hs ? prev_x : '0;
      checks++;
      if (o_e !== prev_hs || o_x !== exp_x) begin
        failures++;
        $display("FAIL pixel_out c=%0d: got e=%0b x=%0d expected e=%0b x=%0d",
                 c, o_e, o_x, prev_hs, exp_x);
      end
      if (o_e === 1'b1) out_px.push_back(int'(o_x));
      exp_ready = m_on && (c >= m_ready_at);
      checks++;
      if (s_ready !== exp_ready) begin
        failures++;
        $display("FAIL s_ready c=%0d: got %0b expected %0b", c, s_ready, exp_ready);
      end
      exp_busy = (k_last < 0) || (c <= k_last + 1 + IDLE);
      exp_done = (k_last >= 0) && (c == k_last + 1 + IDLE);
      checks++;
      if (o_busy !== exp_busy || o_done !== exp_done || o_err !== 1'b0) begin
        failures++;
        $display("FAIL status c=%0d: got busy=%0b done=%0b err=%0b expected busy=%0b done=%0b err=0",
                 c, o_busy, o_done, o_err, exp_busy, exp_done);
      end
      if (in_run) begin
        if (s_ready === 1'b1) begin
          obs_runs.push_back(run_cnt);
          in_run = 1'b0;
        end else begin
          run_cnt++;
        end
      end
      if (k_last >= 0 && c == k_last + 2 + IDLE) begin
        fin = 1'b1;
      end else if (abort_px > 0 && n_hs == abort_px) begin
        rstn = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_sof, o_e, o_busy, o_done, o_err, s_ready} !== 6'b0 || o_w !== '0 || o_h !== '0 || o_x !== '0) begin
          failures++;
          $display("FAIL abort_zero: got sof=%0b e=%0b busy=%0b done=%0b err=%0b rdy=%0b x=%0d expected all 0",
                   o_sof, o_e, o_busy, o_done, o_err, s_ready, o_x);
        end
        rstn = 1'b1;
        m_lfsr = SEED;
        for (int j = 0; j < 40; j++) begin
          @(negedge clk);
          checks++;
          if ({o_sof, o_e, o_busy, o_done, s_ready} !== 5'b0) begin
            failures++;
            $display("FAIL abort_quiet j=%0d: got sof=%0b e=%0b busy=%0b done=%0b rdy=%0b expected 0",
                     j, o_sof, o_e, o_busy, o_done, s_ready);
          end
        end
        fin = 1'b1;
      end else begin
        if (vpat == 0) v = 1'b1;
        else if (vpat == 1) v = ($urandom_range(0, 9) < 7);
        else v = (c % 4 == 0) || (c % 4 == 3);
        s_valid = v && (idx < n_px);
        s_data  = (idx < n_px) ? XW'(sent_px[idx]) : '0;
        prev_hs = s_valid && (s_ready === 1'b1);
        prev_x  = s_data;
        if (prev_hs) begin
          n_hs++;
          if (idx == n_px - 1) begin
            k_last = c; m_on = 1'b0;
          end else begin
            nb = model_bubbles(mode, bnum, m_lfsr);
            m_ready_at = c + 1 + nb;
            in_run = 1'b1; run_cnt = 0;
          end
          m_lfsr = model_shift(m_lfsr);
          idx++;
        end
      end
    end
    if (!fin) begin
      checks++; failures++;
      $display("FAIL timeout: got %0d pixels after %0d cycles expected %0d", idx, budget, n_px);
      pulse_reset();
    end else if (abort_px == 0) begin
      checks++;
      if (out_px.size() != n_px) begin
        failures++;
        $display("FAIL px_count: got %0d expected %0d", out_px.size(), n_px);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; i_start = 1'b0; i_w = '0; i_h = '0; i_bmode = 2'd0; i_bnum = '0;
    s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_sof, o_e, o_busy, o_done, o_err, s_ready} !== 6'b0 || o_w !== '0 || o_h !== '0 || o_x !== '0) begin
      failures++;
      $display("FAIL reset_state: got sof=%0b e=%0b busy=%0b done=%0b err=%0b rdy=%0b expected all 0",
               o_sof, o_e, o_busy, o_done, o_err, s_ready);
    end
    rstn = 1'b1;
    m_lfsr = SEED;
    @(negedge clk);
    checks++;
    if ({o_sof, o_busy, s_ready} !== 3'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got sof=%0b busy=%0b rdy=%0b expected 0", o_sof, o_busy, s_ready);
    end
  endtask

  task automatic test_basic();
    run_frame(4, 0, 0, 0, 0, 10, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= out_px.size() || out_px[i] != 10 + i) begin
        failures++;
        $display("FAIL basic_px[%0d]: got %0d expected %0d", i, (i < out_px.size()) ? out_px[i] : -1, 10 + i);
      end
    end
  endtask

  task automatic test_fixed_bubbles();
    run_frame(7, 1, 1, 3, 0, -1, 0, 1'b0);
    checks++;
    if (obs_runs.size() != 15) begin
      failures++;
      $display("FAIL fixed_run_count: got %0d expected 15", obs_runs.size());
    end
    foreach (obs_runs[i]) begin
      checks++;
      if (obs_runs[i] != 3) begin
        failures++;
        $display("FAIL fixed_run[%0d]: got %0d expected 3", i, obs_runs[i]);
      end
    end
  endtask

  task automatic test_random_bubbles();
    int runs1[$];
    int bad;
    pulse_reset();
    run_frame(63, 3, 2, 5, 0, -1, 0, 1'b0);
    runs1 = obs_runs;
    bad = 0;
    foreach (runs1[i]) if (runs1[i] > 5) bad++;
    checks++;
    if (runs1.size() != 255 || bad != 0) begin
      failures++;
      $display("FAIL rand_runs: got %0d runs with %0d above 5 expected 255 runs with 0 above 5", runs1.size(), bad);
    end
    pulse_reset();
    run_frame(63, 3, 2, 5, 0, -1, 0, 1'b0);
    bad = 0;
    foreach (runs1[i]) if (i >= obs_runs.size() || obs_runs[i] != runs1[i]) bad++;
    checks++;
    if (bad != 0 || obs_runs.size() != runs1.size()) begin
      failures++;
      $display("FAIL rand_repeat: got %0d differing runs expected 0", bad);
    end
  endtask

  task automatic test_throttle();
    int bad;
    run_frame(5, 1, 1, 1, 2, -1, 0, 1'b0);
    bad = 0;
    foreach (sent_px[i]) if (i >= out_px.size() || out_px[i] != sent_px[i]) bad++;
    checks++;
    if (bad != 0 || out_px.size() != sent_px.size()) begin
      failures++;
      $display("FAIL throttle_order: got %0d misplaced of %0d expected 0", bad, sent_px.size());
    end
    bad = 0;
    foreach (obs_runs[i]) if (obs_runs[i] != 1) bad++;
    checks++;
    if (bad != 0 || obs_runs.size() != 11) begin
      failures++;
      $display("FAIL throttle_bubbles: got %0d runs with %0d not 1 expected 11 runs of 1", obs_runs.size(), bad);
    end
  endtask

  task automatic test_reject();
    @(negedge clk);
    i_start = 1'b1; i_w = WW'(3); i_h = WW'(2); i_bmode = 2'd0; i_bnum = '0;
    @(negedge clk);
    i_start = 1'b0;
    checks++;
    if (o_err !== 1'b1 || o_busy !== 1'b0 || o_sof !== 1'b0) begin
      failures++;
      $display("FAIL reject_err: got err=%0b busy=%0b sof=%0b expected err=1 busy=0 sof=0", o_err, o_busy, o_sof);
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      checks++;
      if ({o_err, o_busy, o_sof, s_ready} !== 4'b0) begin
        failures++;
        $display("FAIL reject_idle j=%0d: got err=%0b busy=%0b sof=%0b rdy=%0b expected 0",
                 j, o_err, o_busy, o_sof, s_ready);
      end
    end
    run_frame(4, 1, 0, 0, 0, -1, 0, 1'b1);
  endtask

  task automatic test_reset_abort();
    run_frame(9, 2, 0, 0, 0, -1, 10, 1'b0);
    run_frame(4, 1, 1, 2, 0, -1, 0, 1'b0);
    checks++;
    if (out_px.size() != 10) begin
      failures++;
      $display("FAIL after_abort_count: got %0d expected 10", out_px.size());
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++)
      run_frame($urandom_range(4, 12), $urandom_range(0, 2), $urandom_range(0, 3),
                $urandom_range(0, 15), 1, -1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fixed_bubbles();
    test_random_bubbles();
    test_throttle();
    test_reject();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jls_frame_feeder.md
Name: jls_frame_feeder

Overview:
Synthesizable pixel-stream front end for jls_encoder. It takes an image header and a valid/ready pixel stream, and produces the encoder's frame protocol: an i_sof preamble, a pixel-enable stream, programmable or pseudo-random bubbles, and an inter-frame idle gap. It replaces bench-only stimulus with hardware that generalises pixel width, preamble length, gap length and bubble mode. It sits between a DMA/line-buffer source and jls_encoder.

Parameters:
XW, 8, pixel bit width (o_x, s_data)
WW, 14, width/height field width
SOF_CYCLES, 368, cycles o_sof is held per frame (≥1)
IDLE_CYCLES, 16, all-zero cycles after the last pixel (≥1)
BW, 4, bubble count field width
MIN_W, 5, minimum supported image width
LFSR_SEED, 16'hACE1, reset value of the bubble LFSR (nonzero)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
i_start  in  1  frame start request, sampled only in IDLE
i_w  in  WW  image width minus 1
i_h  in  WW  image height minus 1
i_bmode  in  2  0 = no bubbles, 1 = fixed i_bnum, 2 = random 0..i_bnum, 3 = same as 0
i_bnum  in  BW  bubble count or bubble bound
s_valid  in  1  source pixel valid
s_ready  out  1  feeder accepts a pixel
s_data  in  XW  source pixel
o_sof  out  1  to encoder i_sof
o_w  out  WW  to encoder i_w; latched width, driven only while o_sof=1, else 0
o_h  out  WW  to encoder i_h; same rule as o_w
o_e  out  1  to encoder i_e
o_x  out  XW  to encoder i_x; 0 when o_e=0
o_busy  out  1  frame in progress
o_done  out  1  1-cycle pulse at end of gap
o_err  out  1  1-cycle pulse when a start request is rejected

Behaviour:
- Clock and reset: one clock, clk. rstn is synchronous and active-low. Reset forces state IDLE, all outputs 0, s_ready=0, counters 0, LFSR=LFSR_SEED. A reset mid-frame aborts the frame immediately: no o_done, no further o_e.
- All encoder-facing outputs (o_sof, o_w, o_h, o_e, o_x) are registered.
- FSM states: IDLE, SOF, PIX, BUB, GAP.
- IDLE: o_busy=0, s_ready=0. If i_start=1 at cycle T:
  - If i_w+1 < MIN_W: o_err=1 at T+1, stay in IDLE.
  - Otherwise latch i_w, i_h, i_bmode and i_bnum, then go to SOF.
  - o_busy=1 from T+1 until o_done inclusive.
- SOF: o_sof=1 and o_w/o_h=latched values for exactly cycles T+1..T+SOF_CYCLES. o_e=0 throughout.
  - s_ready rises in cycle T+SOF_CYCLES, so the first pixel can appear at o_e in T+SOF_CYCLES+1 with no gap.
- PIX: s_ready=1. A handshake (s_valid & s_ready) at cycle k gives o_e=1, o_x=s_data at k+1.
  - s_valid=0 produces o_e=0 cycles only. Source stalls do not consume programmed bubbles.
  - Column and row counters advance per accepted pixel; the column wraps at latched w and then increments the row.
- Bubbles after accepted pixel k (not the last pixel):
  - n=0 for mode 0/3; n=i_bnum for mode 1.
  - Mode 2: n = (lfsr[7:0] × (i_bnum+1)) >> 8, so 0..i_bnum.
  - If n>0 go to BUB: s_ready=0 for cycles k+1..k+n, back to PIX with s_ready=1 at k+n+1. If n=0, stay in PIX with s_ready continuously high.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts once per accepted pixel. Only the LFSR value before the shift is used to compute n.
- Last pixel (row=h, col=w) accepted at k: s_ready drops at k+1, no bubbles; go to GAP.
  - o_e=0, o_sof=0, o_x=0 for cycles k+2..k+1+IDLE_CYCLES.
  - o_done=1 in cycle k+1+IDLE_CYCLES, then IDLE. i_start is accepted from the next cycle.
- i_start while o_busy=1 is ignored (no o_err).
- Header/bubble inputs changing mid-frame have no effect; latched values are used.
- Total o_e count per frame is exactly (w+1)·(h+1). Width 1-pixel images are rejected via MIN_W; h=0 (single row) is legal.

Test Plan:
1. Reset, i_w=4, i_h=0, mode 0, s_valid=1 with data 10..14 → o_sof high exactly 368 cycles with o_w=4, o_h=0; o_e high 5 consecutive cycles with o_x=10,11,12,13,14; 16 zero cycles; single o_done; o_busy low next cycle.
2. i_w=7, i_h=1, mode 1, i_bnum=3 → each o_e pulse followed by exactly 3 zero cycles, except none after the 16th pixel; 16 o_e total.
3. Mode 2, i_bnum=5, 64×4 image, seed default → every bubble run length is in 0..5 and matches the reference LFSR model; the sequence repeats identically after reset.
4. Source throttling: s_valid toggled 1,0,0,1 while mode 1, i_bnum=1 → stall cycles plus 1 bubble per pixel; no pixel lost or duplicated; o_x order is preserved.
5. i_start with i_w=3 → o_err pulse, no o_sof, o_busy stays 0. i_start pulsed mid-frame → ignored.
6. rstn low during PIX after 10 pixels → next cycle all outputs 0, state IDLE, no o_done. A new frame afterwards completes normally.
